// File: rtl/hqm_core_pkg.sv
// Shared types and widths for the CHP ordered-fragment count control path.
package hqm_core_pkg;

  localparam int unsigned HQM_CHP_FRAG_CNT_W = 5;
  localparam int unsigned HQM_CHP_FRAG_RES_W = 2;

  typedef enum logic [1:0] {
    FRAG_CTRL_INIT,
    FRAG_CTRL_IDLE,
    FRAG_CTRL_RSP
  } frag_ctrl_state_t;

endpackage

// File: rtl/hqm_AW_residue_check.sv
// Mod-3 residue checker: flags when the stored residue disagrees with the data.
module hqm_AW_residue_check #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       r,
  output logic             err
);

  // Recompute the residue and compare against the stored one.
  always_comb begin
    err = (r != 2'(a % WIDTH'(3)));
  end

endmodule

// File: rtl/hqm_AW_residue_gen.sv
// Mod-3 residue generator.
module hqm_AW_residue_gen #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  output logic [1:0]       r
);

  // Constant-divisor modulus; synthesises to a small reduction tree.
  always_comb begin
    r = 2'(a % WIDTH'(3));
  end

endmodule

// File: rtl/hqm_credit_hist_pipe_frag_count_ctrl.sv
// Per-PP ordered-fragment count storage with init sweep, checker pipe updates and
// CFG read/write access, plus a saturating residue-error counter.
module hqm_credit_hist_pipe_frag_count_ctrl
  import hqm_core_pkg::*;
#(
  parameter int unsigned NUM_PP = 64,
  parameter int unsigned CNT_W  = HQM_CHP_FRAG_CNT_W,
  parameter int unsigned RES_W  = HQM_CHP_FRAG_RES_W,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                            hqm_gated_clk,
  input  logic                            hqm_gated_rst,
  output logic [NUM_PP*(CNT_W+RES_W)-1:0] frag_count_reg_f,
  input  logic                            frag_count_reg_load,
  input  logic [NUM_PP*(CNT_W+RES_W)-1:0] frag_count_reg_nxt,
  input  logic                            frag_count_res_err,
  output logic                            pipe_stall,
  input  logic                            cfg_req_v,
  output logic                            cfg_req_ready,
  input  logic                            cfg_req_we,
  input  logic [5:0]                      cfg_req_pp,
  input  logic [CNT_W-1:0]                cfg_req_wdata,
  input  logic                            cfg_clr_all,
  output logic                            cfg_rsp_v,
  input  logic                            cfg_rsp_ready,
  output logic [CNT_W+RES_W-1:0]          cfg_rsp_rdata,
  output logic                            cfg_rsp_err,
  output logic [ERR_W-1:0]                res_err_cnt,
  input  logic                            res_err_clr,
  output logic                            init_done
);

  localparam int unsigned EW   = CNT_W + RES_W;
  localparam int unsigned PtrW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  logic [NUM_PP*EW-1:0] mem_q;
  frag_ctrl_state_t     state_q;
  logic [PtrW-1:0]      ptr_q;
  logic                 init_done_q;
  logic                 rsp_v_q;
  logic [EW-1:0]        rsp_rdata_q;
  logic                 rsp_err_q;
  logic [ERR_W-1:0]     err_cnt_q;

  logic                 cfg_accept;
  logic                 cfg_pp_in_range;
  logic [EW-1:0]        rd_entry;
  logic                 rd_res_err;
  logic [RES_W-1:0]     wr_res;
  logic [EW-1:0]        wr_entry;

  hqm_AW_residue_gen #(
    .WIDTH (CNT_W)
  ) u_res_gen (
    .a (cfg_req_wdata),
    .r (wr_res)
  );

  hqm_AW_residue_check #(
    .WIDTH (CNT_W)
  ) u_res_chk (
    .a   (rd_entry[CNT_W-1:0]),
    .r   (rd_entry[EW-1:CNT_W]),
    .err (rd_res_err)
  );

  // CFG request decode; the pipe has strict priority over CFG in IDLE.
  always_comb begin
    cfg_req_ready   = (state_q == FRAG_CTRL_IDLE) && !frag_count_reg_load;
    cfg_accept      = cfg_req_v && cfg_req_ready;
    cfg_pp_in_range = ({1'b0, cfg_req_pp} < 7'(NUM_PP));
    rd_entry        = cfg_pp_in_range ? mem_q[cfg_req_pp*EW +: EW] : '0;
    wr_entry        = {wr_res, cfg_req_wdata};
  end

  // Storage has no reset; it is only ever cleared by the init sweep.
  always_ff @(posedge hqm_gated_clk) begin
    if (state_q == FRAG_CTRL_INIT) begin
      mem_q[ptr_q*EW +: EW] <= '0;
    end else if (frag_count_reg_load) begin
      mem_q <= frag_count_reg_nxt;
    end else if (cfg_accept && cfg_req_we && cfg_pp_in_range) begin
      mem_q[cfg_req_pp*EW +: EW] <= wr_entry;
    end
  end

  // Control FSM: init sweep, CFG accept, response hold. clr_all acts like reset.
  always_ff @(posedge hqm_gated_clk) begin
    if (hqm_gated_rst) begin
      state_q     <= FRAG_CTRL_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (cfg_clr_all) begin
      state_q     <= FRAG_CTRL_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rsp_v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        FRAG_CTRL_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PtrW'(NUM_PP - 1)) begin
            state_q     <= FRAG_CTRL_IDLE;
            init_done_q <= 1'b1;
          end
        end
        FRAG_CTRL_IDLE: begin
          if (cfg_accept) begin
            state_q <= FRAG_CTRL_RSP;
            rsp_v_q <= 1'b1;
            if (cfg_req_we) begin
              rsp_rdata_q <= cfg_pp_in_range ? wr_entry : '0;
              rsp_err_q   <= !cfg_pp_in_range;
            end else begin
              rsp_rdata_q <= rd_entry;
              rsp_err_q   <= !cfg_pp_in_range || rd_res_err;
            end
          end
        end
        FRAG_CTRL_RSP: begin
          if (cfg_rsp_ready) begin
            state_q <= FRAG_CTRL_IDLE;
            rsp_v_q <= 1'b0;
          end
        end
        default: state_q <= FRAG_CTRL_INIT;
      endcase
    end
  end

  // Saturating residue-error counter; clear wins but a coincident pulse still counts.
  always_ff @(posedge hqm_gated_clk) begin
    if (hqm_gated_rst) begin
      err_cnt_q <= '0;
    end else if (res_err_clr) begin
      err_cnt_q <= frag_count_res_err ? ERR_W'(1) : '0;
    end else if (frag_count_res_err && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign frag_count_reg_f = mem_q;
  assign pipe_stall       = !init_done_q;
  assign init_done        = init_done_q;
  assign cfg_rsp_v        = rsp_v_q;
  assign cfg_rsp_rdata    = rsp_rdata_q;
  assign cfg_rsp_err      = rsp_err_q;
  assign res_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_hqm_credit_hist_pipe_frag_count_ctrl.sv
// Randomized self-checking bench for the fragment count control block.
module tb_hqm_credit_hist_pipe_frag_count_ctrl;

  localparam int NPP = 64;
  localparam int IW  = NPP * 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] frag_count_reg_f;
  logic          frag_count_reg_load;
  logic [IW-1:0] frag_count_reg_nxt;
  logic          frag_count_res_err;
  logic          pipe_stall;
  logic          cfg_req_v;
  logic          cfg_req_ready;
  logic          cfg_req_we;
  logic [5:0]    cfg_req_pp;
  logic [4:0]    cfg_req_wdata;
  logic          cfg_clr_all;
  logic          cfg_rsp_v;
  logic          cfg_rsp_ready;
  logic [6:0]    cfg_rsp_rdata;
  logic          cfg_rsp_err;
  logic [7:0]    res_err_cnt;
  logic          res_err_clr;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  // Reference model: one entry per PP as plain count and residue values.
  int m_cnt [NPP];
  int m_res [NPP];
  int m_err;

  always #5 clk = ~clk;

  hqm_credit_hist_pipe_frag_count_ctrl dut (
    .hqm_gated_clk       (clk),
    .hqm_gated_rst       (rst),
    .frag_count_reg_f    (frag_count_reg_f),
    .frag_count_reg_load (frag_count_reg_load),
    .frag_count_reg_nxt  (frag_count_reg_nxt),
    .frag_count_res_err  (frag_count_res_err),
    .pipe_stall          (pipe_stall),
    .cfg_req_v           (cfg_req_v),
    .cfg_req_ready       (cfg_req_ready),
    .cfg_req_we          (cfg_req_we),
    .cfg_req_pp          (cfg_req_pp),
    .cfg_req_wdata       (cfg_req_wdata),
    .cfg_clr_all         (cfg_clr_all),
    .cfg_rsp_v           (cfg_rsp_v),
    .cfg_rsp_ready       (cfg_rsp_ready),
    .cfg_rsp_rdata       (cfg_rsp_rdata),
    .cfg_rsp_err         (cfg_rsp_err),
    .res_err_cnt         (res_err_cnt),
    .res_err_clr         (res_err_clr),
    .init_done           (init_done)
  );

  function automatic logic [6:0] ent(int c, int r);
    logic [6:0] e;
    e = 7'(r * 32 + c);
    return e;
  endfunction

  function automatic logic [IW-1:0] model_img();
    logic [IW-1:0] v;
    for (int i = 0; i < NPP; i++) v[i*7 +: 7] = ent(m_cnt[i], m_res[i]);
    return v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < NPP; i++) begin
      m_cnt[i] = 0;
      m_res[i] = 0;
    end
  endtask

  // One CFG transaction with bounded waits; ok=0 if either wait expires.
  task automatic do_cfg(input logic we, input logic [5:0] pp, input logic [4:0] wd,
                        output logic [6:0] rd, output logic er, output logic ok);
    logic acc;
    acc = 1'b0;
    ok  = 1'b0;
    rd  = '0;
    er  = 1'b0;
    @(negedge clk);
    cfg_req_v = 1'b1; cfg_req_we = we; cfg_req_pp = pp; cfg_req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      #1;
      acc = cfg_req_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    @(negedge clk);
    cfg_req_v = 1'b0;
    if (acc) begin
      for (int i = 0; i < 100; i++) begin
        #1;
        if (cfg_rsp_v) begin
          rd = cfg_rsp_rdata;
          er = cfg_rsp_err;
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      @(posedge clk);
    end
  endtask

  task automatic pipe_load(input logic [IW-1:0] img);
    @(negedge clk);
    frag_count_reg_load = 1'b1;
    frag_count_reg_nxt  = img;
    @(posedge clk);
    @(negedge clk);
    frag_count_reg_load = 1'b0;
  endtask

  // Counts sampled cycles with pipe_stall high, starting at the current negedge.
  task automatic count_stall(output int n);
    n = 0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (!pipe_stall) break;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [6:0] rd;
    logic er, ok;
    int pps [3];
    pps[0] = 0; pps[1] = 31; pps[2] = 63;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (cfg_rsp_v !== 1'b0 || cfg_rsp_rdata !== 7'h00 || cfg_rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp: v=%b rdata=%h err=%b required 0/00/0",
               cfg_rsp_v, cfg_rsp_rdata, cfg_rsp_err);
    end
    total++;
    if (res_err_cnt !== 8'd0 || init_done !== 1'b0 || cfg_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: cnt=%0d init_done=%b ready=%b required 0/0/0",
               res_err_cnt, init_done, cfg_req_ready);
    end
    count_stall(n);
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL reset_sweep_len: stall cycles=%0d required 64", n);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL reset_init_done: got %b required 1", init_done);
    end
    model_zero();
    total++;
    if (frag_count_reg_f !== model_img()) begin
      bad++;
      $display("FAIL reset_image: image not all zero after sweep");
    end
    for (int k = 0; k < 3; k++) begin
      do_cfg(1'b0, 6'(pps[k]), 5'd0, rd, er, ok);
      total++;
      if (!ok || rd !== 7'h00 || er !== 1'b0) begin
        bad++;
        $display("FAIL reset_read pp=%0d: ok=%b rdata=%h err=%b required 1/00/0",
                 pps[k], ok, rd, er);
      end
    end
  endtask

  task automatic test_write_read();
    logic [6:0] rd;
    logic er, ok;
    do_cfg(1'b1, 6'd5, 5'd16, rd, er, ok);
    m_cnt[5] = 16; m_res[5] = 16 % 3;
    total++;
    if (!ok || rd !== 7'h30 || er !== 1'b0) begin
      bad++;
      $display("FAIL write_rsp: ok=%b rdata=%h err=%b required 1/30/0", ok, rd, er);
    end
    do_cfg(1'b0, 6'd5, 5'd0, rd, er, ok);
    total++;
    if (!ok || rd !== 7'h30 || er !== 1'b0) begin
      bad++;
      $display("FAIL read_back: ok=%b rdata=%h err=%b required 1/30/0", ok, rd, er);
    end
  endtask

  task automatic test_random();
    logic [6:0] rd, exp_rd;
    logic er, ok, exp_er;
    int op, pp, c;
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 2));
      pp = int'($urandom_range(0, NPP - 1));
      if (op == 0) begin
        for (int i = 0; i < NPP; i++) begin
          m_cnt[i] = int'($urandom_range(0, 16));
          m_res[i] = m_cnt[i] % 3;
        end
        pipe_load(model_img());
        #1;
        total++;
        if (frag_count_reg_f !== model_img()) begin
          bad++;
          $display("FAIL rand_load it=%0d: image differs from loaded image", it);
        end
      end else if (op == 1) begin
        c = int'($urandom_range(0, 16));
        do_cfg(1'b1, 6'(pp), 5'(c), rd, er, ok);
        m_cnt[pp] = c; m_res[pp] = c % 3;
        exp_rd = ent(c, c % 3);
        total++;
        if (!ok || rd !== exp_rd || er !== 1'b0) begin
          bad++;
          $display("FAIL rand_write it=%0d pp=%0d: ok=%b rdata=%h err=%b required 1/%h/0",
                   it, pp, ok, rd, er, exp_rd);
        end
      end else begin
        do_cfg(1'b0, 6'(pp), 5'd0, rd, er, ok);
        exp_rd = ent(m_cnt[pp], m_res[pp]);
        exp_er = (m_res[pp] != m_cnt[pp] % 3);
        total++;
        if (!ok || rd !== exp_rd || er !== exp_er) begin
          bad++;
          $display("FAIL rand_read it=%0d pp=%0d: ok=%b rdata=%h err=%b required 1/%h/%b",
                   it, pp, ok, rd, er, exp_rd, exp_er);
        end
      end
    end
    #1;
    total++;
    if (frag_count_reg_f !== model_img()) begin
      bad++;
      $display("FAIL rand_final_image: image differs from model");
    end
  endtask

  task automatic test_collision();
    logic [6:0] exp_rd;
    c_block: begin
      m_cnt[9] = int'($urandom_range(1, 16));
      m_res[9] = m_cnt[9] % 3;
    end
    exp_rd = ent(m_cnt[9], m_res[9]);
    @(negedge clk);
    frag_count_reg_load = 1'b1;
    frag_count_reg_nxt  = model_img();
    cfg_req_v = 1'b1; cfg_req_we = 1'b0; cfg_req_pp = 6'd9;
    #1;
    total++;
    if (cfg_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL collide_ready_low: ready=%b required 0", cfg_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    frag_count_reg_load = 1'b0;
    #1;
    total++;
    if (cfg_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL collide_ready_high: ready=%b required 1", cfg_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_req_v = 1'b0;
    #1;
    total++;
    if (cfg_rsp_v !== 1'b1 || cfg_rsp_rdata !== exp_rd || cfg_rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL collide_rsp: v=%b rdata=%h err=%b required 1/%h/0",
               cfg_rsp_v, cfg_rsp_rdata, cfg_rsp_err, exp_rd);
    end
    @(posedge clk);
  endtask

  task automatic test_corrupt();
    logic [6:0] rd;
    logic er, ok;
    int pp;
    pp = int'($urandom_range(0, NPP - 1));
    m_cnt[pp] = 4; m_res[pp] = 0;
    pipe_load(model_img());
    do_cfg(1'b0, 6'(pp), 5'd0, rd, er, ok);
    total++;
    if (!ok || rd !== 7'h04 || er !== 1'b1) begin
      bad++;
      $display("FAIL corrupt_read pp=%0d: ok=%b rdata=%h err=%b required 1/04/1",
               pp, ok, rd, er);
    end
  endtask

  task automatic pulse_err(input int n, input logic clr);
    @(negedge clk);
    frag_count_res_err = (n > 0);
    res_err_clr = clr;
    repeat ((n > 0) ? n : 1) @(negedge clk);
    frag_count_res_err = 1'b0;
    res_err_clr = 1'b0;
    #1;
  endtask

  task automatic test_res_err();
    int n;
    pulse_err(0, 1'b1);
    m_err = 0;
    n = int'($urandom_range(1, 100));
    pulse_err(n, 1'b0);
    m_err = (m_err + n > 255) ? 255 : m_err + n;
    total++;
    if (res_err_cnt !== 8'(m_err)) begin
      bad++;
      $display("FAIL err_cnt_partial: got %0d required %0d", res_err_cnt, m_err);
    end
    pulse_err(300, 1'b0);
    m_err = (m_err + 300 > 255) ? 255 : m_err + 300;
    total++;
    if (res_err_cnt !== 8'(m_err)) begin
      bad++;
      $display("FAIL err_cnt_sat: got %0d required %0d", res_err_cnt, m_err);
    end
    pulse_err(1, 1'b1);
    m_err = 1;
    total++;
    if (res_err_cnt !== 8'(m_err)) begin
      bad++;
      $display("FAIL err_clr_pulse: got %0d required %0d", res_err_cnt, m_err);
    end
    pulse_err(0, 1'b1);
    m_err = 0;
    total++;
    if (res_err_cnt !== 8'(m_err)) begin
      bad++;
      $display("FAIL err_clr_only: got %0d required %0d", res_err_cnt, m_err);
    end
  endtask

  task automatic test_clr_all();
    logic [6:0] rd, exp_rd;
    logic er, ok;
    int pp, c, n;
    pp = int'($urandom_range(0, NPP - 1));
    c  = int'($urandom_range(1, 16));
    do_cfg(1'b1, 6'(pp), 5'(c), rd, er, ok);
    m_cnt[pp] = c; m_res[pp] = c % 3;
    exp_rd = ent(c, c % 3);
    @(negedge clk);
    cfg_rsp_ready = 1'b0;
    cfg_req_v = 1'b1; cfg_req_we = 1'b0; cfg_req_pp = 6'(pp);
    @(posedge clk);
    @(negedge clk);
    cfg_req_v = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (cfg_rsp_v !== 1'b1 || cfg_rsp_rdata !== exp_rd) begin
      bad++;
      $display("FAIL clr_rsp_held: v=%b rdata=%h required 1/%h", cfg_rsp_v, cfg_rsp_rdata, exp_rd);
    end
    cfg_clr_all = 1'b1;
    @(negedge clk);
    cfg_clr_all = 1'b0;
    #1;
    total++;
    if (cfg_rsp_v !== 1'b0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_drop: rsp_v=%b init_done=%b required 0/0", cfg_rsp_v, init_done);
    end
    cfg_rsp_ready = 1'b1;
    count_stall(n);
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL clr_sweep_len: stall cycles=%0d required 64", n);
    end
    model_zero();
    do_cfg(1'b0, 6'(pp), 5'd0, rd, er, ok);
    total++;
    if (!ok || rd !== 7'h00 || er !== 1'b0) begin
      bad++;
      $display("FAIL clr_read pp=%0d: ok=%b rdata=%h err=%b required 1/00/0", pp, ok, rd, er);
    end
    #1;
    total++;
    if (frag_count_reg_f !== model_img()) begin
      bad++;
      $display("FAIL clr_image: image not all zero after clear");
    end
  endtask

  initial begin
    rst = 1'b1;
    frag_count_reg_load = 1'b0;
    frag_count_reg_nxt  = '0;
    frag_count_res_err  = 1'b0;
    cfg_req_v     = 1'b0;
    cfg_req_we    = 1'b0;
    cfg_req_pp    = '0;
    cfg_req_wdata = '0;
    cfg_clr_all   = 1'b0;
    cfg_rsp_ready = 1'b1;
    res_err_clr   = 1'b0;
    m_err = 0;
    model_zero();
    test_reset();
    test_write_read();
    test_random();
    test_collision();
    test_corrupt();
    test_res_err();
    test_clr_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
